// File: rtl/gpio_ws281x_drv.sv
// rtl/gpio_ws281x_drv.sv - single-channel WS281x serial LED driver with pixel FIFO
//
// Serialises 24-bit pixel words MSB-first as NRZ high/low pulses, then holds the
// line low for a latch period once the FIFO runs dry.
//
// Ports:
//   mclk        system clock
//   h_reset     synchronous active-high reset
//   cfg_enable  driver enable; low aborts transmission and flushes the FIFO
//   cfg_t0h     high time of a '0' bit (mclk cycles, 0 treated as 1)
//   cfg_t1h     high time of a '1' bit (mclk cycles, 0 treated as 1)
//   cfg_tbit    total bit period (mclk cycles, 0 treated as 1)
//   cfg_treset  latch low time after the last pixel (mclk cycles, 0 treated as 1)
//   pix_valid   push request
//   pix_data    pixel word, bit 23 sent first
//   pix_ready   FIFO can accept a word
//   fifo_cnt    FIFO occupancy
//   ws_dout     registered serial output to the pad
//   busy        transmitter not idle

module gpio_ws281x_drv #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        mclk,
    input  logic                        h_reset,
    input  logic                        cfg_enable,
    input  logic [CNT_W-1:0]            cfg_t0h,
    input  logic [CNT_W-1:0]            cfg_t1h,
    input  logic [CNT_W-1:0]            cfg_tbit,
    input  logic [CNT_W-1:0]            cfg_treset,
    input  logic                        pix_valid,
    input  logic [23:0]                 pix_data,
    output logic                        pix_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        ws_dout,
    output logic                        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HIGH,
        ST_LOW,
        ST_RST
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [23:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fifo_cnt;
    logic             r_live;
    logic [23:0]      r_shift;
    logic [4:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;

    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_push;
    logic             w_pop;
    logic             w_cnt_zero;
    logic             w_dout_next;
    logic [23:0]      w_head;
    logic [CNT_W-1:0] w_t0h;
    logic [CNT_W-1:0] w_t1h;
    logic [CNT_W-1:0] w_tbit;
    logic [CNT_W-1:0] w_treset;
    logic [CNT_W-1:0] w_th_cur;
    logic [CNT_W-1:0] w_th_next;
    logic [CNT_W-1:0] w_th_head;
    logic [CNT_W-1:0] w_tlow;

    // Zero-valued timing fields behave as one cycle.
    assign w_t0h    = (cfg_t0h    == '0) ? ONE : cfg_t0h;
    assign w_t1h    = (cfg_t1h    == '0) ? ONE : cfg_t1h;
    assign w_tbit   = (cfg_tbit   == '0) ? ONE : cfg_tbit;
    assign w_treset = (cfg_treset == '0) ? ONE : cfg_treset;

    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == FULL_CNT);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_cnt_zero   = (r_cnt == '0);

    // High time of the bit on the line now, of the bit after the next shift,
    // and of the MSB of the word about to be popped.
    assign w_th_cur  = r_shift[23] ? w_t1h : w_t0h;
    assign w_th_next = r_shift[22] ? w_t1h : w_t0h;
    assign w_th_head = w_head[23]  ? w_t1h : w_t0h;

    // Low part of the bit; never shorter than one cycle even if tbit <= thigh.
    assign w_tlow = (w_tbit > w_th_cur) ? (w_tbit - w_th_cur) : ONE;

    // r_live keeps pix_ready low for the cycle right after a reset.
    assign pix_ready = cfg_enable & r_live & ~w_fifo_full;
    assign w_push    = pix_valid & pix_ready;

    assign fifo_cnt = r_fifo_cnt;
    assign ws_dout  = r_dout;
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (!w_fifo_empty) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_HIGH;
            ST_HIGH: if (w_cnt_zero) w_next_state = ST_LOW;
            ST_LOW: begin
                if (w_cnt_zero) begin
                    if ((r_bit_cnt != 5'd0) || !w_fifo_empty) begin
                        w_next_state = ST_HIGH;
                    end else begin
                        w_next_state = ST_RST;
                    end
                end
            end
            ST_RST:  if (w_cnt_zero) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (!cfg_enable) begin
            w_next_state = ST_IDLE;
        end
    end

    // Pops happen on LOAD and on the last cycle of a pixel when another word
    // is waiting, which keeps consecutive pixels gapless.
    always_comb begin
        w_pop = 1'b0;
        if (cfg_enable) begin
            case (r_state)
                ST_LOAD: w_pop = 1'b1;
                ST_LOW:  w_pop = w_cnt_zero && (r_bit_cnt == 5'd0) && !w_fifo_empty;
                default: w_pop = 1'b0;
            endcase
        end
        w_dout_next = (w_next_state == ST_HIGH);
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pix_data;
        end
    end

    always_ff @(posedge mclk) begin
        if (h_reset || !cfg_enable) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_cnt      <= '0;
            r_dout     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - CNT_ONE;
            end

            r_dout <= w_dout_next;

            case (r_state)
                ST_LOAD: begin
                    r_shift   <= w_head;
                    r_bit_cnt <= 5'd23;
                    r_cnt     <= w_th_head - ONE;
                end
                ST_HIGH: begin
                    r_cnt <= w_cnt_zero ? (w_tlow - ONE) : (r_cnt - ONE);
                end
                ST_LOW: begin
                    if (w_cnt_zero) begin
                        if (r_bit_cnt != 5'd0) begin
                            r_shift   <= {r_shift[22:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                            r_cnt     <= w_th_next - ONE;
                        end else if (!w_fifo_empty) begin
                            r_shift   <= w_head;
                            r_bit_cnt <= 5'd23;
                            r_cnt     <= w_th_head - ONE;
                        end else begin
                            r_cnt <= w_treset - ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                ST_RST: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_ws281x_drv.sv
// tb/tb_gpio_ws281x_drv.sv - self-checking bench for gpio_ws281x_drv

module tb_gpio_ws281x_drv;

    localparam int DEPTH = 4;
    localparam int MI = 0;
    localparam int ML = 1;
    localparam int MT = 2;
    localparam int MR = 3;

    logic        mclk;
    logic        h_reset;
    logic        cfg_enable;
    logic [15:0] cfg_t0h;
    logic [15:0] cfg_t1h;
    logic [15:0] cfg_tbit;
    logic [15:0] cfg_treset;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic [2:0]  fifo_cnt;
    logic        ws_dout;
    logic        busy;

    gpio_ws281x_drv #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (16)
    ) dut (
        .mclk      (mclk),
        .h_reset   (h_reset),
        .cfg_enable(cfg_enable),
        .cfg_t0h   (cfg_t0h),
        .cfg_t1h   (cfg_t1h),
        .cfg_tbit  (cfg_tbit),
        .cfg_treset(cfg_treset),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .fifo_cnt  (fifo_cnt),
        .ws_dout   (ws_dout),
        .busy      (busy)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_vec;
    int n_err;
    bit chk_en;

    // Model: pending words plus the exact waveform still owed for the pixel in flight.
    logic [23:0] m_fifo[$];
    bit          m_wave[$];
    int          m_mode;
    int          m_rst_left;
    bit          m_cur;
    bit          m_live;
    bit          m_rdy;
    bit          m_ne;

    int hi_cnt;
    int busy_cnt;
    int full_cnt;
    int run_len;
    bit prev_dout;
    int q_pulse[$];

    int s_hi;
    int s_busy;
    int s_pul;
    int s_full;
    int n_push;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp1(input logic [15:0] v);
        return (v == 16'd0) ? 1 : int'(v);
    endfunction

    function automatic void start_pixel();
        logic [23:0] w;
        w = m_fifo.pop_front();
        for (int b = 23; b >= 0; b--) begin
            int th;
            int tb;
            int tl;
            th = clamp1(w[b] ? cfg_t1h : cfg_t0h);
            tb = clamp1(cfg_tbit);
            tl = (tb > th) ? tb - th : 1;
            repeat (th) m_wave.push_back(1'b1);
            repeat (tl) m_wave.push_back(1'b0);
        end
        m_cur = m_wave.pop_front();
    endfunction

    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic push_lat(input logic [23:0] d);
        pix_valid = 1'b1;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
        @(negedge mclk);
        check("lat_idle_busy", 32'(busy), 32'd0);
        @(negedge mclk);
        check("lat_load_busy", 32'(busy), 32'd1);
        check("lat_load_dout", 32'(ws_dout), 32'd0);
        @(negedge mclk);
        check("lat_first_high", 32'(ws_dout), 32'd1);
        tick();
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        do begin
            @(negedge mclk);
            k++;
        end while ((busy || fifo_cnt != 3'd0) && k < max);
        check("idle_within_budget", 32'(busy == 1'b0 && fifo_cnt == 3'd0), 32'd1);
        tick();
    endtask

    task automatic snap();
        s_hi   = hi_cnt;
        s_busy = busy_cnt;
        s_pul  = q_pulse.size();
        s_full = full_cnt;
    endtask

    initial begin
        h_reset    = 1'b1;
        cfg_enable = 1'b0;
        cfg_t0h    = 16'd4;
        cfg_t1h    = 16'd8;
        cfg_tbit   = 16'd12;
        cfg_treset = 16'd50;
        pix_valid  = 1'b0;
        pix_data   = 24'd0;
        n_vec = 0; n_err = 0; chk_en = 1'b0;
        m_mode = MI; m_rst_left = 0; m_cur = 1'b0; m_live = 1'b0;
        hi_cnt = 0; busy_cnt = 0; full_cnt = 0; run_len = 0; prev_dout = 1'b0;

        fork
            begin
                forever begin
                    @(posedge mclk);
                    m_rdy = cfg_enable && m_live && (m_fifo.size() < DEPTH);
                    m_ne  = (m_fifo.size() != 0);
                    if (h_reset) begin
                        m_fifo.delete(); m_wave.delete();
                        m_mode = MI; m_cur = 1'b0; m_live = 1'b0;
                    end else if (!cfg_enable) begin
                        m_fifo.delete(); m_wave.delete();
                        m_mode = MI; m_cur = 1'b0; m_live = 1'b1;
                    end else begin
                        m_live = 1'b1;
                        case (m_mode)
                            MI: begin
                                m_cur = 1'b0;
                                if (m_ne) m_mode = ML;
                            end
                            ML: begin
                                start_pixel();
                                m_mode = MT;
                            end
                            MT: begin
                                if (m_wave.size() != 0) begin
                                    m_cur = m_wave.pop_front();
                                end else if (m_ne) begin
                                    start_pixel();
                                end else begin
                                    m_mode = MR;
                                    m_rst_left = clamp1(cfg_treset);
                                    m_cur = 1'b0;
                                end
                            end
                            default: begin
                                m_cur = 1'b0;
                                m_rst_left--;
                                if (m_rst_left == 0) m_mode = MI;
                            end
                        endcase
                        if (pix_valid && m_rdy) m_fifo.push_back(pix_data);
                    end
                end
            end
            begin
                forever begin
                    @(negedge mclk);
                    if (chk_en) begin
                        check("ws_dout", 32'(ws_dout), 32'(m_cur));
                        check("busy", 32'(busy), 32'(m_mode != MI));
                        check("fifo_cnt", 32'(fifo_cnt), 32'(m_fifo.size()));
                        check("pix_ready", 32'(pix_ready),
                              32'(cfg_enable && m_live && (m_fifo.size() < DEPTH)));
                    end
                    if (ws_dout) begin
                        hi_cnt++;
                        run_len++;
                    end else if (prev_dout) begin
                        q_pulse.push_back(run_len);
                        run_len = 0;
                    end
                    prev_dout = ws_dout;
                    if (busy) busy_cnt++;
                    if (fifo_cnt == 3'd4 && !pix_ready) full_cnt++;
                end
            end
        join_none

        // Reset state
        tick();
        chk_en = 1'b1;
        @(negedge mclk);
        check("rst_dout", 32'(ws_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo", 32'(fifo_cnt), 32'd0);
        check("rst_ready", 32'(pix_ready), 32'd0);
        tick();
        h_reset    = 1'b0;
        cfg_enable = 1'b1;
        tick();

        // Single pixel, '1' timing
        snap();
        push_lat(24'hA00000);
        wait_idle(600);
        check("t1_highs", 32'(hi_cnt - s_hi), 32'd104);
        check("t1_busy", 32'(busy_cnt - s_busy), 32'd339);
        check("t1_pulses", 32'(q_pulse.size() - s_pul), 32'd24);
        check("t1_bit23_high", 32'(q_pulse[s_pul]), 32'd8);
        check("t1_bit22_high", 32'(q_pulse[s_pul + 1]), 32'd4);

        // Back-to-back pixels
        snap();
        pix_valid = 1'b1;
        pix_data = 24'hFFFFFF; tick();
        pix_data = 24'h000000; tick();
        pix_data = 24'h5A5A5A; tick();
        pix_valid = 1'b0;
        wait_idle(1500);
        check("b2b_highs", 32'(hi_cnt - s_hi), 32'd432);
        check("b2b_busy", 32'(busy_cnt - s_busy), 32'd915);
        check("b2b_pulses", 32'(q_pulse.size() - s_pul), 32'd72);

        // FIFO full / backpressure
        snap();
        n_push = 0;
        for (int i = 0; i < 8; i++) begin
            int   g;
            logic acc;
            logic [7:0] ib;
            ib = 8'(i);
            pix_valid = 1'b1;
            pix_data  = {ib, 8'hF0, 8'h0F};
            g = 0;
            acc = 1'b0;
            while (!acc && g < 1000) begin
                @(negedge mclk);
                acc = pix_ready;
                @(posedge mclk);
                #2;
                g++;
            end
            if (acc) n_push++;
        end
        pix_valid = 1'b0;
        check("bp_pushes", 32'(n_push), 32'd8);
        wait_idle(3000);
        check("bp_highs", 32'(hi_cnt - s_hi), 32'd1072);
        check("bp_busy", 32'(busy_cnt - s_busy), 32'd2355);
        check("bp_pulses", 32'(q_pulse.size() - s_pul), 32'd192);
        check("bp_full_seen", 32'((full_cnt - s_full) > 0), 32'd1);

        // Abort mid-bit of the second of three queued pixels
        pix_valid = 1'b1;
        pix_data = 24'h123456; tick();
        pix_data = 24'hABCDEF; tick();
        pix_data = 24'h0F0F0F; tick();
        pix_valid = 1'b0;
        repeat (293) tick();
        cfg_enable = 1'b0;
        tick();
        snap();
        @(negedge mclk);
        check("ab_dout", 32'(ws_dout), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_fifo", 32'(fifo_cnt), 32'd0);
        check("ab_ready", 32'(pix_ready), 32'd0);
        repeat (4) tick();
        check("ab_no_rst_busy", 32'(busy_cnt - s_busy), 32'd0);
        check("ab_no_rst_high", 32'(hi_cnt - s_hi), 32'd0);
        cfg_enable = 1'b1;
        snap();
        push_lat(24'hA00000);
        wait_idle(600);
        check("ab_restart_highs", 32'(hi_cnt - s_hi), 32'd104);

        // Clamp / boundary, then push during RST
        cfg_t0h    = 16'd0;
        cfg_t1h    = 16'd8;
        cfg_tbit   = 16'd5;
        cfg_treset = 16'd50;
        tick();
        snap();
        push_lat(24'h800000);
        repeat (136) tick();
        pix_valid = 1'b1;
        pix_data  = 24'h000001;
        tick();
        pix_valid = 1'b0;
        @(negedge mclk);
        check("cl_rst_dout", 32'(ws_dout), 32'd0);
        check("cl_rst_busy", 32'(busy), 32'd1);
        check("cl_rst_fifo", 32'(fifo_cnt), 32'd1);
        tick();
        wait_idle(1000);
        check("cl_highs", 32'(hi_cnt - s_hi), 32'd62);
        check("cl_busy", 32'(busy_cnt - s_busy), 32'd350);
        check("cl_pulses", 32'(q_pulse.size() - s_pul), 32'd48);
        check("cl_bit23_high", 32'(q_pulse[s_pul]), 32'd8);
        check("cl_bit22_high", 32'(q_pulse[s_pul + 1]), 32'd1);
        check("cl_px2_first", 32'(q_pulse[s_pul + 24]), 32'd1);
        check("cl_px2_last", 32'(q_pulse[s_pul + 47]), 32'd8);

        // Sync reset mid-frame
        cfg_t0h    = 16'd4;
        cfg_t1h    = 16'd8;
        cfg_tbit   = 16'd12;
        cfg_treset = 16'd50;
        tick();
        push_lat(24'hA00000);
        repeat (2) tick();
        h_reset = 1'b1;
        tick();
        h_reset = 1'b0;
        @(negedge mclk);
        check("sr_dout", 32'(ws_dout), 32'd0);
        check("sr_busy", 32'(busy), 32'd0);
        check("sr_fifo", 32'(fifo_cnt), 32'd0);
        check("sr_ready", 32'(pix_ready), 32'd0);
        tick();
        snap();
        push_lat(24'hA00000);
        wait_idle(600);
        check("sr_highs", 32'(hi_cnt - s_hi), 32'd104);
        check("sr_pulses", 32'(q_pulse.size() - s_pul), 32'd24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
